// File: rtl/wb_stage_pkg.sv
// Shared MIPS decode constants and enums for the write-back stage.
package mips_defs;

    // Primary opcodes (IR[31:26]) that produce a register write
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    // R-type function codes (IR[5:0]) that differ from plain rd <= ALUO
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // Link register used by jal
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_DM,
        WB_PC8
    } wb_src_e;

    typedef enum logic [2:0] {
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } ld_kind_e;

    // Pick the addressed byte/half out of the aligned memory word and extend it.
    // Little-endian lanes; for halfwords only addr[1] matters.
    function automatic logic [31:0] load_extend(input ld_kind_e   kind,
                                                input logic [31:0] word,
                                                input logic [1:0]  addr);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        shifted = word >> {addr, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr[1] ? word[31:16] : word[15:0];
        case (kind)
            LD_B:    load_extend = {{24{byte_v[7]}}, byte_v};
            LD_BU:   load_extend = {24'h0, byte_v};
            LD_H:    load_extend = {{16{half_v[15]}}, half_v};
            LD_HU:   load_extend = {16'h0, half_v};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_grf.sv
// 32x32 general register file: $0 hardwired to zero, one write port,
// two combinational read ports with same-cycle write bypass.
module grf
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  a3,
    input  logic [31:0] wd,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    // $0 has no storage; only registers 1..31 exist
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    // Next register-file contents: the current contents with the W-stage write applied
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves a latch.
        regs_d = regs_q;
        if (we && (a3 != 5'd0)) begin
            regs_d[a3] = wd;
        end
    end

    // Register-file state update with synchronous clear
    always_ff @(posedge clk) begin
        // NOTE: this array is architectural state that must read 0 after reset,
        // so it is cleared explicitly (a flop array, not an inferred RAM).
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                // NOTE: sequential state uses <= so all flops update from pre-edge values.
                regs_q[i] <= 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: $0 always 0, otherwise an in-flight write wins over stored data
    always_comb begin
        rd1 = 32'h0;
        rd2 = 32'h0;
        if (a1 != 5'd0) begin
            rd1 = (we && (a3 == a1)) ? wd : regs_q[a1];
        end
        if (a2 != 5'd0) begin
            rd2 = (we && (a3 == a2)) ? wd : regs_q[a2];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: decodes W_IR, extends loads, writes the GRF,
// exports the W-stage write for forwarding, counts retires and traces writes.
module wb_stage
    import mips_defs::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter bit          TRACE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      W_PC,
    input  logic [31:0]      W_IR,
    input  logic [31:0]      W_DMRD,
    input  logic [31:0]      W_ALUO,
    input  logic [31:0]      W_PC8,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    output logic [31:0]      D_RD1,
    output logic [31:0]      D_RD2,
    output logic             W_WE,
    output logic [4:0]       W_A3,
    output logic [31:0]      W_WD,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_a3,
    output logic [31:0]      trace_wd
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
    wb_src_e     wb_src;
    ld_kind_e    ld_kind;
    logic [4:0]  dst;
    logic [31:0] wb_data;

    // rs and shamt play no part in write-back
    logic        unused_ir_bits;
    assign unused_ir_bits = ^{W_IR[25:21], W_IR[10:6]};

    assign op = W_IR[31:26];
    assign fn = W_IR[5:0];
    assign rt = W_IR[20:16];
    assign rd = W_IR[15:11];

    // Decode destination register, data source and load kind
    always_comb begin
        wb_src  = WB_NONE;
        ld_kind = LD_W;
        dst     = 5'd0;
        case (op)
            OP_RTYPE: begin
                dst = rd;
                if (fn == FN_JR) begin
                    wb_src = WB_NONE;
                end else if (fn == FN_JALR) begin
                    wb_src = WB_PC8;
                end else begin
                    wb_src = WB_ALU;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                dst    = rt;
                wb_src = WB_ALU;
            end
            OP_JAL: begin
                dst    = REG_RA;
                wb_src = WB_PC8;
            end
            OP_LW:  begin dst = rt; wb_src = WB_DM; ld_kind = LD_W;  end
            OP_LB:  begin dst = rt; wb_src = WB_DM; ld_kind = LD_B;  end
            OP_LBU: begin dst = rt; wb_src = WB_DM; ld_kind = LD_BU; end
            OP_LH:  begin dst = rt; wb_src = WB_DM; ld_kind = LD_H;  end
            OP_LHU: begin dst = rt; wb_src = WB_DM; ld_kind = LD_HU; end
            default: begin
                wb_src = WB_NONE;
            end
        endcase
    end

    // Select write data and qualify the write; $0 and reset suppress it
    always_comb begin
        case (wb_src)
            WB_ALU:  wb_data = W_ALUO;
            WB_DM:   wb_data = load_extend(ld_kind, W_DMRD, W_ALUO[1:0]);
            WB_PC8:  wb_data = W_PC8;
            default: wb_data = 32'h0;
        endcase
        W_WE = (wb_src != WB_NONE) && (dst != 5'd0) && !rst;
        W_A3 = W_WE ? dst     : 5'd0;
        W_WD = W_WE ? wb_data : 32'h0;
    end

    grf u_grf (
        .clk (clk),
        .rst (rst),
        .we  (W_WE),
        .a3  (W_A3),
        .wd  (W_WD),
        .a1  (D_A1),
        .a2  (D_A2),
        .rd1 (D_RD1),
        .rd2 (D_RD2)
    );

    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             trace_valid_q, trace_valid_d;
    logic [31:0]      trace_pc_q, trace_pc_d;
    logic [4:0]       trace_a3_q, trace_a3_d;
    logic [31:0]      trace_wd_q, trace_wd_d;

    // Next retire count and trace capture; trace fields hold unless a write occurs
    always_comb begin
        retire_cnt_d  = retire_cnt_q;
        trace_valid_d = TRACE_EN && W_WE;
        trace_pc_d    = trace_pc_q;
        trace_a3_d    = trace_a3_q;
        trace_wd_d    = trace_wd_q;
        if (W_IR != 32'h0) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
        if (trace_valid_d) begin
            trace_pc_d = W_PC;
            trace_a3_d = W_A3;
            trace_wd_d = W_WD;
        end
    end

    // Counter and trace registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q  <= '0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'h0;
            trace_a3_q    <= 5'd0;
            trace_wd_q    <= 32'h0;
        end else begin
            retire_cnt_q  <= retire_cnt_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_a3_q    <= trace_a3_d;
            trace_wd_q    <= trace_wd_d;
        end
    end

    assign retire_cnt  = retire_cnt_q;
    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_a3    = trace_a3_q;
    assign trace_wd    = trace_wd_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// corner sequences and random instructions against a behavioural model.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] W_PC, W_IR, W_DMRD, W_ALUO, W_PC8;
    logic [4:0]  D_A1, D_A2;

    logic [31:0] D_RD1, D_RD2, W_WD;
    logic        W_WE;
    logic [4:0]  W_A3;
    logic [31:0] retire_cnt;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_wd;
    logic [4:0]  trace_a3;

    // second instance: narrow counter, trace disabled
    logic [31:0] u2_rd1, u2_rd2, u2_wd;
    logic        u2_we;
    logic [4:0]  u2_a3;
    logic [3:0]  u2_cnt;
    logic        u2_tv;
    logic [31:0] u2_tpc, u2_twd;
    logic [4:0]  u2_ta3;

    int total = 0;
    int bad   = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .W_PC(W_PC), .W_IR(W_IR), .W_DMRD(W_DMRD),
        .W_ALUO(W_ALUO), .W_PC8(W_PC8), .D_A1(D_A1), .D_A2(D_A2),
        .D_RD1(D_RD1), .D_RD2(D_RD2), .W_WE(W_WE), .W_A3(W_A3), .W_WD(W_WD),
        .retire_cnt(retire_cnt), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_a3(trace_a3), .trace_wd(trace_wd)
    );

    wb_stage #(.CNT_W(4), .TRACE_EN(1'b0)) dut4 (
        .clk(clk), .rst(rst), .W_PC(W_PC), .W_IR(W_IR), .W_DMRD(W_DMRD),
        .W_ALUO(W_ALUO), .W_PC8(W_PC8), .D_A1(D_A1), .D_A2(D_A2),
        .D_RD1(u2_rd1), .D_RD2(u2_rd2), .W_WE(u2_we), .W_A3(u2_a3), .W_WD(u2_wd),
        .retire_cnt(u2_cnt), .trace_valid(u2_tv), .trace_pc(u2_tpc),
        .trace_a3(u2_ta3), .trace_wd(u2_twd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        m_tv;
    logic [31:0] m_tpc, m_twd;
    logic [4:0]  m_ta3;

    // values the DUT showed before the last clock edge
    logic        cap_we;
    logic [4:0]  cap_a3;
    logic [31:0] cap_wd, cap_rd1, cap_rd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What the instruction architecturally writes, straight from the ISA rules
    function automatic void m_decode(input logic [31:0] ir, dmrd, aluo, pc8,
                                     output logic we, output logic [4:0] a3,
                                     output logic [31:0] wd);
        int unsigned op, fn, b, h;
        op = ir[31:26];
        fn = ir[5:0];
        we = 1'b1;
        a3 = ir[20:16];
        wd = aluo;
        if (op == 0) begin
            a3 = ir[15:11];
            if (fn == 8) we = 1'b0;
            else if (fn == 9) wd = pc8;
        end else if (op == 3) begin
            a3 = 31;
            wd = pc8;
        end else if (op == 8 || op == 9 || op == 10 || op == 12 || op == 13 || op == 15) begin
            wd = aluo;
        end else if (op == 'h23) begin
            wd = dmrd;
        end else if (op == 'h20 || op == 'h24) begin
            b  = (dmrd >> (8 * (aluo % 4))) % 256;
            wd = (op == 'h20 && b >= 128) ? b + 32'hFFFFFF00 : b;
        end else if (op == 'h21 || op == 'h25) begin
            h  = ((aluo % 4) >= 2) ? dmrd / 65536 : dmrd % 65536;
            wd = (op == 'h21 && h >= 32768) ? h + 32'hFFFF0000 : h;
        end else begin
            we = 1'b0;
        end
        if (a3 == 0) we = 1'b0;
        if (!we) begin
            a3 = 0;
            wd = 0;
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] a3, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && a3 == a) return wd;
        return m_regs[a];
    endfunction

    // One W-stage cycle: drive, check combinational outputs, clock, check state
    task automatic step(input logic r, input logic [31:0] ir, pc, dmrd, aluo, pc8,
                        input logic [4:0] a1, a2);
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        rst = r; W_IR = ir; W_PC = pc; W_DMRD = dmrd; W_ALUO = aluo; W_PC8 = pc8;
        D_A1 = a1; D_A2 = a2;
        #1;
        m_decode(ir, dmrd, aluo, pc8, we, a3, wd);
        if (r) begin
            we = 1'b0; a3 = 0; wd = 0;
        end
        check("w_we", 32'(W_WE), 32'(we));
        check("w_a3", 32'(W_A3), 32'(a3));
        check("w_wd", W_WD, wd);
        check("d_rd1", D_RD1, m_read(a1, we, a3, wd));
        check("d_rd2", D_RD2, m_read(a2, we, a3, wd));
        check("u2_w", {u2_wd[26:0], u2_we, u2_a3}, {wd[26:0], we, a3});
        check("u2_rd", u2_rd1 ^ u2_rd2, m_read(a1, we, a3, wd) ^ m_read(a2, we, a3, wd));
        cap_we = W_WE; cap_a3 = W_A3; cap_wd = W_WD; cap_rd1 = D_RD1; cap_rd2 = D_RD2;
        @(posedge clk);
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_cnt = 0; m_tv = 0; m_tpc = 0; m_ta3 = 0; m_twd = 0;
        end else begin
            if (we) m_regs[a3] = wd;
            if (ir != 0) m_cnt = m_cnt + 1;
            m_tv = we;
            if (we) begin
                m_tpc = pc; m_ta3 = a3; m_twd = wd;
            end
        end
        #1;
        check("retire_cnt", retire_cnt, m_cnt);
        check("retire_cnt4", 32'(u2_cnt), 32'(m_cnt[3:0]));
        check("trace_valid", 32'(trace_valid), 32'(m_tv));
        check("trace_pc", trace_pc, m_tpc);
        check("trace_a3", 32'(trace_a3), 32'(m_ta3));
        check("trace_wd", trace_wd, m_twd);
        check("u2_trace", {u2_tpc[26:0], u2_tv, u2_ta3} ^ u2_twd, 32'h0);
    endtask

    // Read every register through both ports with a bubble in W (no clock edge)
    task automatic check_regs();
        rst = 1'b0; W_IR = 32'h0;
        for (int a = 0; a < 32; a++) begin
            D_A1 = 5'(a);
            D_A2 = 5'(31 - a);
            #1;
            check("reg_rd1", D_RD1, (a == 0) ? 32'h0 : m_regs[a]);
            check("reg_rd2", D_RD2, (a == 31) ? 32'h0 : m_regs[31 - a]);
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fns [9] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00, 6'h08, 6'h09};
        logic [5:0]  ops [17] = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h03, 6'h23,
                                  6'h20, 6'h24, 6'h21, 6'h25, 6'h2b, 6'h04, 6'h02, 6'h3f, 6'h0b};
        int unsigned k;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        k   = $urandom_range(0, 21);
        if (k < 4) return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 8)]};
        if (k == 21) return 32'h0;
        return {ops[k - 4], rs, rt, imm};
    endfunction

    typedef struct {
        logic [31:0] ir;
        logic [31:0] dmrd;
        logic [31:0] aluo;
        logic [31:0] pc8;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] ir, saved;
        logic [4:0]  a1, a2;

        vecs[0]  = '{32'h34051234, 32'h0,        32'h00001234, 32'h0,        1'b1, 5'd5,  32'h00001234}; // ori $5
        vecs[1]  = '{32'h80080003, 32'h80FF7F01, 32'h00000003, 32'h0,        1'b1, 5'd8,  32'hFFFFFF80}; // lb
        vecs[2]  = '{32'h90080003, 32'h80FF7F01, 32'h00000003, 32'h0,        1'b1, 5'd8,  32'h00000080}; // lbu
        vecs[3]  = '{32'h84080000, 32'h80FF7F01, 32'h00001000, 32'h0,        1'b1, 5'd8,  32'h00007F01}; // lh lo
        vecs[4]  = '{32'h94080002, 32'h80FF7F01, 32'h00001002, 32'h0,        1'b1, 5'd8,  32'h000080FF}; // lhu hi
        vecs[5]  = '{32'h8C0A0000, 32'hCAFEF00D, 32'h00002000, 32'h0,        1'b1, 5'd10, 32'hCAFEF00D}; // lw
        vecs[6]  = '{32'h00220021, 32'h0,        32'h00000055, 32'h0,        1'b0, 5'd0,  32'h0};        // addu $0
        vecs[7]  = '{32'h0C000100, 32'h0,        32'h0,        32'h00400108, 1'b1, 5'd31, 32'h00400108}; // jal
        vecs[8]  = '{32'hAC050004, 32'h0,        32'h00000044, 32'h0,        1'b0, 5'd0,  32'h0};        // sw
        vecs[9]  = '{32'h10A50003, 32'h0,        32'h00000001, 32'h0,        1'b0, 5'd0,  32'h0};        // beq
        vecs[10] = '{32'h00A03809, 32'h0,        32'h0,        32'h00001000, 1'b1, 5'd7,  32'h00001000}; // jalr
        vecs[11] = '{32'h03E00008, 32'h0,        32'h00000099, 32'h00000777, 1'b0, 5'd0,  32'h0};        // jr
        vecs[12] = '{32'h3C0CABCD, 32'h0,        32'hABCD0000, 32'h0,        1'b1, 5'd12, 32'hABCD0000}; // lui
        vecs[13] = '{32'hFC0D0000, 32'h12345678, 32'h00000004, 32'h0,        1'b0, 5'd0,  32'h0};        // unknown
        vecs[14] = '{32'h00221821, 32'h0,        32'h00000077, 32'h0,        1'b1, 5'd3,  32'h00000077}; // addu $3

        rst = 1'b1; W_IR = 0; W_PC = 0; W_DMRD = 0; W_ALUO = 0; W_PC8 = 0; D_A1 = 0; D_A2 = 0;
        foreach (m_regs[i]) m_regs[i] = 'x;
        m_cnt = 'x; m_tv = 'x; m_tpc = 'x; m_ta3 = 'x; m_twd = 'x;
        @(posedge clk);
        #1;

        // reset state
        step(1'b1, 32'h34051234, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 5'd0);
        check("rst_we", 32'(cap_we), 32'h0);
        check("rst_cnt", retire_cnt, 32'h0);
        check("rst_tv", 32'(trace_valid), 32'h0);
        check_regs();

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            step(1'b0, vecs[i].ir, 32'h00400000 + 32'(4 * i), vecs[i].dmrd, vecs[i].aluo,
                 vecs[i].pc8, vecs[i].exp_a3, 5'd0);
            check("vec_we", 32'(cap_we), 32'(vecs[i].exp_we));
            check("vec_a3", 32'(cap_a3), 32'(vecs[i].exp_a3));
            check("vec_wd", cap_wd, vecs[i].exp_wd);
            check("vec_tv", 32'(trace_valid), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check("vec_tpc", trace_pc, 32'h00400000 + 32'(4 * i));
                check("vec_ta3", 32'(trace_a3), 32'(vecs[i].exp_a3));
                check("vec_twd", trace_wd, vecs[i].exp_wd);
            end
        end
        check("vec_cnt", retire_cnt, 32'd15);
        check_regs();

        // same-cycle bypass to both ports, then $0 never bypassed
        step(1'b0, 32'h00224821, 32'h500, 32'h0, 32'hDEADBEEF, 32'h0, 5'd9, 5'd9);
        check("byp_rd1", cap_rd1, 32'hDEADBEEF);
        check("byp_rd2", cap_rd2, 32'hDEADBEEF);
        step(1'b0, 32'h34090001, 32'h504, 32'h0, 32'h00000001, 32'h0, 5'd0, 5'd9);
        check("byp_a0", cap_rd1, 32'h0);
        check("byp_new", cap_rd2, 32'h00000001);

        // bubbles leave the counter alone
        saved = m_cnt;
        repeat (3) step(1'b0, 32'h0, 32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2);
        check("bubble_cnt", retire_cnt, saved);

        // 5 retires after reset, then 17 wraps the 4-bit counter to 1
        step(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h34100000 | 32'(i), 32'h700 + 32'(4 * i), 32'h0, 32'(i), 32'h0, 5'd16, 5'd1);
        check("cnt5", retire_cnt, 32'd5);
        for (int i = 0; i < 12; i++)
            step(1'b0, 32'hAC050004, 32'h800, 32'h0, 32'h0, 32'h0, 5'd16, 5'd1);
        check("cnt17_w4", 32'(u2_cnt), 32'd1);
        check("cnt17", retire_cnt, 32'd17);

        // load registers, then reset mid-stream during a lw write
        for (int i = 1; i < 8; i++)
            step(1'b0, {6'h0d, 5'd0, 5'(i), 16'h0}, 32'h900, 32'h0, 32'hA0 + 32'(i), 32'h0, 5'(i), 5'd0);
        step(1'b1, 32'h8C040000, 32'h920, 32'h11112222, 32'h0, 32'h0, 5'd4, 5'd4);
        check("rstw_we", 32'(cap_we), 32'h0);
        check("rstw_tv", 32'(trace_valid), 32'h0);
        check("rstw_cnt", retire_cnt, 32'h0);
        check_regs();

        // random traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            ir = rand_ir();
            a1 = ($urandom_range(0, 1) != 0) ? ir[20:16] : 5'($urandom);
            a2 = ($urandom_range(0, 1) != 0) ? ir[15:11] : 5'($urandom);
            step(($urandom_range(0, 49) == 0), ir, $urandom, $urandom, $urandom, $urandom, a1, a2);
            if (n % 50 == 49) check_regs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
